// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the RV32M iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Opcode encoding: bit 1 selects remainder, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  localparam int OP_REM_BIT      = 1;
  localparam int OP_UNSIGNED_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step: shift {rem,quo} left
//            by one, trial-subtract the divisor, keep the difference if it is
//            non-negative and shift in the matching quotient bit.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Trial subtraction is one bit wider than the operands. Because rem < dsr
  // on entry, the shifted value never exceeds 2*dsr, so the top bit of the
  // difference is a reliable sign.
  always_comb begin
    w_shift = {rem, quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, dsr};
    if (w_trial[WIDTH]) begin
      rem_n = w_shift[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = w_trial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : rv_iter_divider
// Brief    : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one
//            quotient bit per cycle. Operands are converted to magnitudes on
//            entry and the sign is restored in the FIX state.
//            Optional macro DIV_EARLY_OUT_EN: special cases (divide by zero,
//            signed overflow) complete straight from IDLE with latency 1.
// Revision : 1.0 - initial release
// ============================================================================
module rv_iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  div_state_t       w_state_n;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_result;
  logic             r_rem_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dsr_zero;

  logic             w_signed;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dsr_abs;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_early;
  logic [WIDTH-1:0] w_early_res;

  // Magnitudes are modulo 2^WIDTH, so the most negative value maps to itself
  // and is then treated as an unsigned magnitude.
  assign w_signed  = ~op[OP_UNSIGNED_BIT];
  assign w_dvd_neg = w_signed & dividend[WIDTH-1];
  assign w_dsr_neg = w_signed & divisor[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
  assign w_dsr_abs = w_dsr_neg ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (divisor == '0) |
                   (w_signed & (dividend == c_min) & (divisor == c_ones));
  assign w_early_res = (divisor == '0) ?
                       (op[OP_REM_BIT] ? dividend : c_ones) :
                       (op[OP_REM_BIT] ? '0 : dividend);
`else
  assign w_early     = 1'b0;
  assign w_early_res = '0;
`endif

  // Signed overflow (MIN / -1) needs no special handling here: |MIN|/1 gives
  // MIN with remainder 0 and equal signs. Divide-by-zero yields an all-ones
  // quotient and rem=|dividend|; only the quotient negation must be skipped.
  assign w_q_fix = r_dsr_zero ? c_ones : (r_neg_q ? -r_quo : r_quo);
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;
  assign result  = r_result;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (r_rem),
    .quo   (r_quo),
    .dsr   (r_dsr),
    .rem_n (w_rem_n),
    .quo_n (w_quo_n)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_n = r_state;
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_state_n = w_early ? DONE : CALC;
      CALC:    if (r_count == c_last) w_state_n = FIX;
      FIX:     w_state_n = DONE;
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsr      <= '0;
      r_result   <= '0;
      r_rem_op   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dsr_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_early) begin
              r_result <= w_early_res;
            end else begin
              r_count    <= '0;
              r_rem      <= '0;
              r_quo      <= w_dvd_abs;
              r_dsr      <= w_dsr_abs;
              r_rem_op   <= op[OP_REM_BIT];
              r_neg_q    <= w_dvd_neg ^ w_dsr_neg;
              r_neg_r    <= w_dvd_neg;
              r_dsr_zero <= (divisor == '0);
            end
          end
        end
        CALC: begin
          r_rem   <= w_rem_n;
          r_quo   <= w_quo_n;
          r_count <= r_count + 1'b1;
        end
        FIX: begin
          r_result <= r_rem_op ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
